// File: rtl/text_line_ctrl.sv
// Text-line controller: double-buffered character store plus a raster-tracking
// scan FSM that feeds character codes and cell positions to a glyph renderer.
module text_line_ctrl #(
    parameter int NCHARS = 16,
    parameter int gsize  = 16,
    parameter int LEAD   = 2,
    localparam int AW    = $clog2(NCHARS)
) (
    input  logic          px_clk,
    input  logic          rstn,
    input  logic [25:0]   RGBStr_i,
    input  logic [9:0]    base_x,
    input  logic [9:0]    base_y,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_char,
    input  logic          commit,
    output logic          armed,
    output logic [7:0]    character,
    output logic [9:0]    pos_x,
    output logic [9:0]    pos_y,
    output logic          line_active
);
    localparam int PW = $clog2(gsize);

    typedef enum logic {C_RUN, C_ARMED} cmt_state_t;
    typedef enum logic [1:0] {S_WAIT_ROW, S_WAIT_X, S_DRAW, S_DONE} scan_state_t;

    logic [9:0]  xc, yc;
    logic        frame_start;
    logic        unused_stream_bits;

    cmt_state_t  cst_q, cst_d;
    logic        bank_q, bank_d;
    scan_state_t sst_q, sst_d;
    logic [AW-1:0] cell_q, cell_d;
    logic [PW-1:0] pix_q, pix_d;
    logic [9:0]  bx_q, by_q;
    logic [7:0]  mem_q [2][NCHARS];

    logic [7:0]  char_q;
    logic [9:0]  pos_x_q, pos_y_q;
    logic        active_q;

    logic [9:0]  row_off, trig_x, cell_px;
    logic        row_hit, wr_fire;

    assign xc                 = RGBStr_i[22:13];
    assign yc                 = RGBStr_i[12:3];
    assign unused_stream_bits = ^{RGBStr_i[25:23], RGBStr_i[2:0]};
    assign frame_start        = (xc == 10'd0) && (yc == 10'd0);

    // Row window and trigger column are evaluated modulo 1024 like every other position.
    assign row_off = yc - by_q;
    assign row_hit = row_off < 10'(gsize);
    assign trig_x  = bx_q - 10'(LEAD);
    assign cell_px = bx_q + 10'(cell_q) * 10'(gsize);
    assign wr_fire = wr_valid && wr_ready;

    always_comb begin
        cst_d    = cst_q;
        bank_d   = bank_q;
        wr_ready = 1'b0;
        armed    = 1'b0;
        case (cst_q)
            C_RUN: begin
                wr_ready = 1'b1;
                if (commit) cst_d = C_ARMED;
            end
            C_ARMED: begin
                armed = 1'b1;
                if (frame_start) begin
                    bank_d = ~bank_q;
                    cst_d  = C_RUN;
                end
            end
            default: cst_d = C_RUN;
        endcase
    end

    always_comb begin
        sst_d  = sst_q;
        cell_d = cell_q;
        pix_d  = pix_q;
        case (sst_q)
            S_WAIT_ROW: if (row_hit) sst_d = S_WAIT_X;
            S_WAIT_X: begin
                if (xc == trig_x) begin
                    sst_d  = S_DRAW;
                    cell_d = '0;
                    pix_d  = '0;
                end
            end
            S_DRAW: begin
                if (pix_q == PW'(gsize - 1)) begin
                    pix_d = '0;
                    if (cell_q == AW'(NCHARS - 1)) begin
                        sst_d  = S_DONE;
                        cell_d = '0;
                    end else begin
                        cell_d = cell_q + 1'b1;
                    end
                end else begin
                    pix_d = pix_q + 1'b1;
                end
            end
            S_DONE: if (xc == 10'd0) sst_d = row_hit ? S_WAIT_X : S_WAIT_ROW;
            default: sst_d = S_WAIT_ROW;
        endcase
        if (frame_start) sst_d = S_WAIT_ROW;
    end

    always_ff @(posedge px_clk) begin
        if (!rstn) begin
            cst_q    <= C_RUN;
            bank_q   <= 1'b0;
            sst_q    <= S_WAIT_ROW;
            cell_q   <= '0;
            pix_q    <= '0;
            bx_q     <= '0;
            by_q     <= '0;
            char_q   <= 8'h20;
            pos_x_q  <= '0;
            pos_y_q  <= '0;
            active_q <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < NCHARS; i++)
                    mem_q[b][i] <= 8'h20;
        end else begin
            cst_q  <= cst_d;
            bank_q <= bank_d;
            sst_q  <= sst_d;
            cell_q <= cell_d;
            pix_q  <= pix_d;
            if (frame_start) begin
                bx_q <= base_x;
                by_q <= base_y;
            end
            if (wr_fire) mem_q[~bank_q][wr_addr] <= wr_char;
            // Renderer outputs trail the DRAW state by one cycle and hold outside it.
            active_q <= (sst_q == S_DRAW);
            if (sst_q == S_DRAW) begin
                char_q  <= mem_q[bank_q][cell_q];
                pos_x_q <= cell_px;
                pos_y_q <= by_q;
            end
        end
    end

    assign character   = char_q;
    assign pos_x       = pos_x_q;
    assign pos_y       = pos_y_q;
    assign line_active = active_q;
endmodule

// File: tb/tb_text_line_ctrl.sv
// Directed + randomized bench for text_line_ctrl with a frame-level reference model.
module tb_text_line_ctrl;
    localparam int NC = 16;
    localparam int GS = 16;

    logic       px_clk = 1'b0;
    logic       rstn;
    logic [9:0] xc_d, yc_d;
    logic [2:0] junk_hi, junk_lo;
    logic [25:0] rgb;
    logic [9:0] base_x, base_y;
    logic       wr_valid, wr_ready, commit, armed, line_active;
    logic [3:0] wr_addr;
    logic [7:0] wr_char, character;
    logic [9:0] pos_x, pos_y;

    always #5 px_clk = ~px_clk;
    assign rgb = {junk_hi, xc_d, yc_d, junk_lo};

    text_line_ctrl #(.NCHARS(NC), .gsize(GS), .LEAD(2)) dut (
        .px_clk(px_clk), .rstn(rstn), .RGBStr_i(rgb),
        .base_x(base_x), .base_y(base_y),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_char(wr_char),
        .commit(commit), .armed(armed),
        .character(character), .pos_x(pos_x), .pos_y(pos_y), .line_active(line_active)
    );

    // Reference model: displayed text, pending text, commit flag, latched bases.
    logic [7:0] m_disp [NC];
    logic [7:0] m_shad [NC];
    logic [7:0] exp_text [NC];
    logic       m_armed;
    logic [9:0] m_bx, m_by;
    bit         wr_once;

    int tests = 0;
    int fails = 0;

    int run_len = 0;
    int runs[$];
    int mm = 0;
    int bad_k;
    logic [7:0] bad_c, bad_ec;
    logic [9:0] bad_px, bad_ep;

    // Each active sample: run index k presents cell k/GS of the displayed text.
    always @(negedge px_clk) begin : mon
        int c;
        logic [7:0] ec;
        logic [9:0] ep;
        if (xc_d == 10'd0 && yc_d == 10'd0) begin
            runs.delete();
            run_len = 0;
            mm = 0;
        end else if (line_active === 1'b1) begin
            c  = run_len / GS;
            ec = (c < NC) ? exp_text[c] : 8'h00;
            ep = m_bx + 10'(c * GS);
            if (c >= NC || character !== ec || pos_x !== ep || pos_y !== m_by) begin
                if (mm == 0) begin
                    bad_k = run_len; bad_c = character; bad_ec = ec; bad_px = pos_x; bad_ep = ep;
                end
                mm++;
            end
            run_len++;
        end else if (run_len != 0) begin
            runs.push_back(run_len);
            run_len = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            m_disp[i] = 8'h20;
            m_shad[i] = 8'h20;
        end
        m_armed = 1'b0;
    endtask

    task automatic tick();
        logic fs, acc;
        logic [7:0] t;
        fs  = (xc_d == 10'd0 && yc_d == 10'd0);
        acc = wr_valid && !m_armed && rstn;
        if (!rstn) begin
            model_reset();
        end else begin
            if (acc) m_shad[wr_addr] = wr_char;
            if (m_armed) begin
                if (fs) begin
                    for (int i = 0; i < NC; i++) begin
                        t = m_disp[i]; m_disp[i] = m_shad[i]; m_shad[i] = t;
                    end
                    m_armed = 1'b0;
                end
            end else if (commit) begin
                m_armed = 1'b1;
            end
            if (fs) begin
                m_bx = base_x;
                m_by = base_y;
                exp_text = m_disp;
            end
        end
        @(posedge px_clk);
        #1;
        commit  = 1'b0;
        junk_hi = 3'($urandom);
        junk_lo = 3'($urandom);
        if (acc && wr_once) begin
            wr_valid = 1'b0;
            wr_once  = 1'b0;
        end
    endtask

    task automatic park(input int n);
        xc_d = 10'd1023;
        yc_d = 10'd1023;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input int a, input logic [7:0] ch);
        wr_valid = 1'b1;
        wr_addr  = 4'(a);
        wr_char  = ch;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        tick();
    endtask

    task automatic frame(input int bx, input int by, input bit cmt_fs, input bit cmt_mid, input bit rst_mid);
        int h;
        base_x = 10'(bx);
        base_y = 10'(by);
        park(1);
        xc_d = 10'd0;
        yc_d = 10'd0;
        if (cmt_fs) commit = 1'b1;
        tick();
        chk("armed_after_fs", armed, m_armed);
        chk("wr_ready_after_fs", wr_ready, !m_armed);
        h = (int'(m_bx) > 1024 - 270) ? 1024 : int'(m_bx) + 270;
        for (int l = 0; l < 16; l++) begin
            yc_d = m_by + 10'(l);
            for (int x = 0; x < h; x++) begin
                xc_d = 10'(x);
                if (l == 2 && x == 0) begin
                    base_x = 10'($urandom);
                    base_y = 10'($urandom);
                end
                if (cmt_mid && l == 0 && x == 1) commit = 1'b1;
                if (rst_mid && l == 1 && x == int'(m_bx) + 20) begin
                    chk("pre_reset_armed", armed, 1);
                    chk("pre_reset_active", line_active, 1);
                    rstn = 1'b0;
                    tick();
                    rstn = 1'b1;
                    chk("rst_mid_char", character, 8'h20);
                    chk("rst_mid_pos_x", pos_x, 0);
                    chk("rst_mid_pos_y", pos_y, 0);
                    chk("rst_mid_active", line_active, 0);
                    chk("rst_mid_wr_ready", wr_ready, 1);
                    chk("rst_mid_armed", armed, 0);
                    park(4);
                    return;
                end
                tick();
                if (cmt_mid && l == 0 && x == 1) begin
                    chk("armed_mid", armed, 1);
                    chk("wr_ready_mid", wr_ready, 0);
                end
            end
        end
        yc_d = m_by + 10'd16;
        xc_d = 10'd0;
        tick();
        park(4);
        if (h == 1024) chk("wrap_runs_present", runs.size() > 0, 1);
        else           chk("run_count", runs.size(), 16);
        foreach (runs[i]) chk("run_length", runs[i], NC * GS);
        tests++;
        assert (mm === 0) else begin
            fails++;
            $error("FAIL content: observed %0d bad samples (first k=%0d char=%0h pos_x=%0d) expected 0 (char=%0h pos_x=%0d)",
                   mm, bad_k, bad_c, bad_px, bad_ec, bad_ep);
        end
    endtask

    initial begin
        rstn = 1'b0; xc_d = 10'd1023; yc_d = 10'd1023; junk_hi = 3'd0; junk_lo = 3'd0;
        base_x = 10'd0; base_y = 10'd0; wr_valid = 1'b0; commit = 1'b0;
        wr_addr = 4'd0; wr_char = 8'd0; wr_once = 1'b0; m_bx = 10'd0; m_by = 10'd0;
        model_reset();
        exp_text = m_disp;
        park(3);
        rstn = 1'b1;
        chk("reset_char", character, 8'h20);
        chk("reset_pos_x", pos_x, 0);
        chk("reset_pos_y", pos_y, 0);
        chk("reset_active", line_active, 0);
        chk("reset_wr_ready", wr_ready, 1);
        chk("reset_armed", armed, 0);

        frame(100, 50, 0, 0, 0);

        wr(0, 8'h48); wr(1, 8'h45); wr(2, 8'h4C); wr(3, 8'h4C); wr(4, 8'h4F);
        frame(100, 50, 0, 1, 0);
        chk("armed_until_fs", armed, 1);
        chk("wr_ready_until_fs", wr_ready, 0);
        frame(100, 50, 0, 0, 0);

        for (int i = 0; i < 4; i++) wr(8 + i, 8'($urandom_range(33, 126)));
        pulse_commit();
        chk("armed_before_hold", armed, 1);
        wr_valid = 1'b1; wr_addr = 4'd7; wr_char = 8'h5A; wr_once = 1'b1;
        park(3);
        chk("wr_ready_held_write", wr_ready, 0);
        frame(64, 200, 0, 0, 0);
        pulse_commit();
        frame(64, 200, 0, 0, 0);

        wr(int'($urandom_range(0, 15)), 8'($urandom_range(33, 126)));
        frame(20, 300, 1, 0, 0);
        frame(20, 300, 0, 0, 0);

        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 3; i++) wr(int'($urandom_range(0, 15)), 8'($urandom));
            pulse_commit();
            frame(int'($urandom_range(4, 60)), int'($urandom_range(2, 900)), 0, 0, 0);
        end

        frame(1000, 30, 0, 0, 0);

        wr(5, 8'h41);
        frame(40, 60, 0, 1, 1);
        frame(40, 60, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/text_line_ctrl.md
TEXT_LINE_CTRL -- requirements
Module: text_line_ctrl

Interface
REQ-001 Parameter NCHARS, default 16: characters per text line; power of two, 2..32.
REQ-002 Parameter gsize, default 16: on-screen glyph cell size in pixels, width and height; multiple of 8.
REQ-003 Parameter LEAD, default 2: number of pixels by which character/pos_x lead the monitored stream, to match renderer pipeline depth.
REQ-004 px_clk  in  1  pixel clock; the only clock.
REQ-005 rstn  in  1  synchronous, active-low reset.
REQ-006 RGBStr_i  in  26  monitored RGB stream; only XC [22:13] and YC [12:3] are used.
REQ-007 base_x  in  10  screen X of cell 0; sampled at frame start.
REQ-008 base_y  in  10  screen Y of the text line; sampled at frame start.
REQ-009 wr_valid  in  1  shadow-buffer write request.
REQ-010 wr_ready  out  1  shadow buffer accepts writes.
REQ-011 wr_addr  in  $clog2(NCHARS)  cell index to write.
REQ-012 wr_char  in  8  character code to write.
REQ-013 commit  in  1  single-cycle pulse: swap shadow and display banks at the next frame start.
REQ-014 armed  out  1  commit pending.
REQ-015 character  out  8  character code for the renderer; registered.
REQ-016 pos_x  out  10  renderer cell X; registered.
REQ-017 pos_y  out  10  renderer cell Y; registered.
REQ-018 line_active  out  1  high while a cell of this line is being presented.

Function
REQ-019 Two banks of NCHARS x 8-bit registers, display and shadow, selected by a 1-bit bank pointer; a swap toggles the pointer and copies no data.
REQ-020 A write occurs on a cycle with wr_valid && wr_ready: shadow[wr_addr] <= wr_char; the new value is visible in the shadow bank on the next cycle.
REQ-021 Frame start is the cycle in which the stream has XC==0 and YC==0.
REQ-022 Commit FSM, state RUN: wr_ready=1, armed=0; a commit pulse moves to ARMED.
REQ-023 State ARMED: wr_ready=0, armed=1; commit pulses are ignored; at frame start, toggle the bank pointer and return to RUN.
REQ-024 A write and a commit in the same cycle: the write is accepted and the FSM still enters ARMED.
REQ-025 A commit during the frame-start cycle: the swap occurs at the following frame start, not in the current one.
REQ-026 base_x and base_y are latched at frame start; changes during a frame take effect at the next frame.
REQ-027 Scan FSM states: WAIT_ROW, WAIT_X, DRAW, DONE.
REQ-028 WAIT_ROW -> WAIT_X when YC is in [by, by+gsize), where by is the latched base_y.
REQ-029 WAIT_X -> DRAW when XC == (bx - LEAD) mod 1024, where bx is the latched base_x. On entry: cell=0, pixel counter=0.
REQ-030 DRAW: the pixel counter increments every cycle. When it reaches gsize-1 it clears and cell increments. After cell NCHARS-1 completes, go to DONE.
REQ-031 DONE -> WAIT_X when XC==0 and the row condition still holds; otherwise -> WAIT_ROW. Frame start forces WAIT_ROW.
REQ-032 In DRAW, on the cycle after each cell change: character = display[cell], pos_x = (bx + cell*gsize) mod 1024, pos_y = by, line_active = 1.
REQ-033 Outside DRAW: line_active = 0, and character, pos_x and pos_y hold their last values.
REQ-034 All position arithmetic is 10-bit, modulo 1024; cells whose positions wrap are presented with the wrapped pos_x and are not clipped.

Reset
REQ-035 rstn low at a rising edge of px_clk sets: both banks all 8'h20, bank pointer 0, commit FSM RUN, scan FSM WAIT_ROW, counters 0.
REQ-036 Reset values of the outputs: character 8'h20, pos_x 0, pos_y 0, line_active 0, wr_ready 1, armed 0.
REQ-037 Reset asserted mid-operation aborts any pending commit and any DRAW sequence; both banks revert to 8'h20.

Verification
REQ-038 Reset, then scan a full frame with base 100/50 -> character=8'h20 for all 16 cells; pos_x = 100,116,...,340; line_active high for 256 consecutive cycles per row, 16 rows.
REQ-039 Write "HELLO" to cells 0..4, pulse commit mid-frame -> armed=1 and wr_ready=0 until frame start; from the next frame character sequence = 48,45,4C,4C,4F,20,...
REQ-040 wr_valid held during ARMED -> no write accepted; the write completes on the first cycle after the swap, when wr_ready=1.
REQ-041 Commit exactly on the frame-start cycle -> swap deferred one full frame.
REQ-042 base_x=1000, NCHARS=16, gsize=16 -> pos_x = 1000,1016,8,24,...
REQ-043 Deassert rstn while in DRAW with armed=1 -> next cycle: all outputs at reset values, armed=0, and the following frame shows all spaces.
